// File: rtl/insn_trace_buffer.sv
// Commit-trace capture buffer: records {pc, insn, timestamp} of retiring instructions in a
// circular buffer, freezes POST_TRIG entries after a trigger, then drains oldest-first.
module insn_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int PC_W      = 32,
    parameter int INSN_W    = 32,
    parameter int TS_W      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [PC_W-1:0]          i_pc,
    input  logic [INSN_W-1:0]        i_insn,
    input  logic                     i_insn_vld,
    input  logic                     i_arm,
    input  logic                     i_clr,
    input  logic                     i_trig_en,
    input  logic [PC_W-1:0]          i_trig_pc,
    input  logic                     i_force_trig,
    input  logic                     i_rd_req,
    output logic                     o_rd_vld,
    output logic [PC_W-1:0]          o_rd_pc,
    output logic [INSN_W-1:0]        o_rd_insn,
    output logic [TS_W-1:0]          o_rd_ts,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [1:0]               o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSN_W + TS_W;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_POST  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]   POST_INIT = CW'(POST_TRIG);
    localparam logic [TS_W-1:0] TS_ONE    = TS_W'(1);

    logic [1:0]        state_q,    state_d;
    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [CW-1:0]     post_cnt_q, post_cnt_d;
    logic [TS_W-1:0]   ts_q;
    logic              rd_vld_q,   rd_vld_d;
    logic [PC_W-1:0]   rd_pc_q,    rd_pc_d;
    logic [INSN_W-1:0] rd_insn_q,  rd_insn_d;
    logic [TS_W-1:0]   rd_ts_q,    rd_ts_d;

    logic [EW-1:0]     mem [DEPTH];
    logic [PC_W-1:0]   ent_pc;
    logic [INSN_W-1:0] ent_insn;
    logic [TS_W-1:0]   ent_ts;

    logic capture;
    logic trigger;

    assign trigger = i_force_trig | (i_trig_en & i_insn_vld & (i_pc == i_trig_pc));
    assign {ent_pc, ent_insn, ent_ts} = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        rd_vld_d   = 1'b0;
        rd_pc_d    = rd_pc_q;
        rd_insn_d  = rd_insn_q;
        rd_ts_d    = rd_ts_q;
        capture    = 1'b0;

        if (i_clr) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_arm) begin
                        state_d  = ST_ARMED;
                        wr_ptr_d = '0;
                        count_d  = '0;
                    end
                end
                ST_ARMED, ST_POST: begin
                    // Re-arming while capturing restarts with an empty buffer.
                    if (i_arm) begin
                        state_d    = ST_ARMED;
                        wr_ptr_d   = '0;
                        count_d    = '0;
                        post_cnt_d = '0;
                    end else begin
                        capture = i_insn_vld;
                        if (state_q == ST_ARMED) begin
                            if (trigger) begin
                                if (POST_TRIG == 0) begin
                                    state_d = ST_DONE;
                                end else begin
                                    state_d    = ST_POST;
                                    post_cnt_d = POST_INIT;
                                end
                            end
                        end else if (i_insn_vld) begin
                            post_cnt_d = post_cnt_q - CNT_ONE;
                            if (post_cnt_q == CNT_ONE) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    if (i_rd_req && (count_q != '0)) begin
                        rd_vld_d  = 1'b1;
                        rd_pc_d   = ent_pc;
                        rd_insn_d = ent_insn;
                        rd_ts_d   = ent_ts;
                        rd_ptr_d  = rd_ptr_q + PTR_ONE;
                        count_d   = count_q - CNT_ONE;
                    end else if (count_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q != CNT_FULL) begin
                count_d = count_q + CNT_ONE;
            end
        end

        // Oldest entry sits count places behind the write pointer once capture stops.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            ts_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_pc_q    <= '0;
            rd_insn_q  <= '0;
            rd_ts_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            ts_q       <= ts_q + TS_ONE;
            rd_vld_q   <= rd_vld_d;
            rd_pc_q    <= rd_pc_d;
            rd_insn_q  <= rd_insn_d;
            rd_ts_q    <= rd_ts_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers define which entries are
    // live, so it can map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            mem[wr_ptr_q] <= {i_pc, i_insn, ts_q};
        end
    end

    assign o_rd_vld  = rd_vld_q;
    assign o_rd_pc   = rd_pc_q;
    assign o_rd_insn = rd_insn_q;
    assign o_rd_ts   = rd_ts_q;
    assign o_count   = count_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_insn_trace_buffer.sv
// Directed bench for insn_trace_buffer: table-driven control vectors plus capture/drain
// sequences checked against a small queue model of the expected trace contents.
module tb_insn_trace_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        vld;
    logic        arm;
    logic        clr;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        force_t;
    logic        rd_req;
    logic        rd_vld;
    logic [31:0] rd_pc;
    logic [31:0] rd_insn;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [15:0] ts;
    } ent_t;

    typedef struct {
        logic        arm;
        logic        clr;
        logic        vld;
        logic [31:0] pc;
        logic        ten;
        logic [31:0] tpc;
        logic        frc;
        logic [1:0]  exp_state;
        logic [4:0]  exp_count;
    } vec_t;

    ent_t        exp_q[$];
    vec_t        vecs[11];
    logic [15:0] tb_ts;
    logic [15:0] popped_ts[16];
    logic [31:0] first_pc;

    insn_trace_buffer #(
        .DEPTH(16), .POST_TRIG(8), .PC_W(32), .INSN_W(32), .TS_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_insn(insn), .i_insn_vld(vld),
        .i_arm(arm), .i_clr(clr), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
        .i_force_trig(force_t), .i_rd_req(rd_req), .o_rd_vld(rd_vld), .o_rd_pc(rd_pc),
        .o_rd_insn(rd_insn), .o_rd_ts(rd_ts), .o_count(count), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: value seen between edges is the timestamp of that cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 16'h0;
        else        tb_ts <= tb_ts + 16'h1;
    end

    function automatic logic [31:0] insn_of(input logic [31:0] p);
        return {p[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 1'b0; clr = 1'b0; vld = 1'b0; force_t = 1'b0; rd_req = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // One valid retire; the model keeps the newest 16 entries like the circular buffer.
    task automatic retire(input logic [31:0] p, input logic f);
        vld = 1'b1; pc = p; insn = insn_of(p); force_t = f;
        exp_q.push_back('{p, insn_of(p), tb_ts});
        if (exp_q.size() > 16) exp_q.delete(0);
        tick();
        vld = 1'b0; force_t = 1'b0;
    endtask

    task automatic drain(input bit gap_chk);
        int          n;
        int          pulses;
        logic [15:0] prev_ts;
        n = exp_q.size();
        pulses = 0;
        prev_ts = 16'h0;
        check("drain_state", state, 2'b11);
        check("drain_count", count, n);
        for (int i = 0; i < n; i++) begin
            rd_req = 1'b1;
            tick();
            if (rd_vld) pulses++;
            check("pop_vld", rd_vld, 1'b1);
            check("pop_pc", rd_pc, exp_q[i].pc);
            check("pop_insn", rd_insn, exp_q[i].insn);
            check("pop_ts", rd_ts, exp_q[i].ts);
            if (gap_chk && i > 0) check("ts_gap", 16'(rd_ts - prev_ts), 16'd2);
            if (i == 0) first_pc = rd_pc;
            if (i < 16) popped_ts[i] = rd_ts;
            prev_ts = rd_ts;
        end
        check("pulses", pulses, n);
        check("empty_count", count, 5'd0);
        check("empty_state", state, 2'b11);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("empty_req_vld", rd_vld, 1'b0);
        check("to_idle", state, 2'b00);
        check("rd_hold_pc", rd_pc, exp_q[n-1].pc);
        exp_q.delete();
    endtask

    initial begin
        idle_inputs();
        pc = '0; insn = '0; trig_en = 1'b0; trig_pc = '0; first_pc = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 2'b00);
        check("rst_count", count, 5'd0);
        check("rst_vld", rd_vld, 1'b0);
        check("rst_pc", rd_pc, 32'h0);
        check("rst_insn", rd_insn, 32'h0);
        check("rst_ts", rd_ts, 16'h0);
        rst_n = 1'b1;
        tick();

        // 1: forced trigger on the 6th retire, 8 post entries, 14 total.
        pulse_arm();
        check("t1_armed", state, 2'b01);
        check("t1_count0", count, 5'd0);
        for (int k = 0; k < 5; k++) retire(32'(4 * k), 1'b0);
        retire(32'h14, 1'b1);
        check("t1_post", state, 2'b10);
        check("t1_count6", count, 5'd6);
        for (int k = 6; k < 14; k++) retire(32'(4 * k), 1'b0);
        check("t1_done", state, 2'b11);
        check("t1_count14", count, 5'd14);
        pulse_arm();
        check("t1_arm_ignored", state, 2'b11);
        check("t1_arm_count", count, 5'd14);
        drain(1'b0);
        check("t1_first_pc", first_pc, 32'h0);

        // 2: PC-match trigger after wrap; oldest entries overwritten.
        trig_en = 1'b1;
        trig_pc = 32'h9C;
        pulse_arm();
        for (int k = 0; k < 48; k++) begin
            retire(32'(4 * k), 1'b0);
            if (k == 19) check("t2_saturate", count, 5'd16);
            if (k == 38) check("t2_still_armed", state, 2'b01);
            if (k == 39) check("t2_trig", state, 2'b10);
            if (k == 46) check("t2_still_post", state, 2'b10);
        end
        trig_en = 1'b0;
        check("t2_done", state, 2'b11);
        drain(1'b0);
        check("t2_first_pc", first_pc, 32'h80);

        // 3: retire strobe on alternate cycles only.
        pulse_arm();
        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0) retire(32'h400 + 32'(4 * (j / 2)), j == 2);
            else tick();
        end
        check("t3_count", count, 5'd10);
        drain(1'b1);

        // Control table: clr against trigger, ignored inputs in IDLE/POST.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b01, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 2'b01, 5'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 2'b01, 5'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b01, 5'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 1'b0, 2'b00, 5'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h10C, 1'b0, 32'h0,   1'b0, 2'b00, 5'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 2'b00, 5'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b01, 5'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 2'b10, 5'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 32'h204, 1'b0, 2'b10, 5'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b00, 5'd0};
        for (int v = 0; v < 11; v++) begin
            arm = vecs[v].arm; clr = vecs[v].clr; vld = vecs[v].vld;
            pc = vecs[v].pc; insn = insn_of(vecs[v].pc);
            trig_en = vecs[v].ten; trig_pc = vecs[v].tpc; force_t = vecs[v].frc;
            tick();
            check($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
            check($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
            check($sformatf("vec%0d_vld", v), rd_vld, 1'b0);
        end
        idle_inputs();
        trig_en = 1'b0;

        // 6: async reset in POST, then a clean re-capture.
        pulse_arm();
        retire(32'h500, 1'b1);
        retire(32'h504, 1'b0);
        retire(32'h508, 1'b0);
        check("t6_pre_state", state, 2'b10);
        check("t6_pre_count", count, 5'd3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", state, 2'b00);
        check("t6_rst_count", count, 5'd0);
        check("t6_rst_vld", rd_vld, 1'b0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        pulse_arm();
        for (int k = 0; k < 12; k++) retire(32'h600 + 32'(4 * k), k == 3);
        check("t6_done", state, 2'b11);
        drain(1'b0);
        check("t6_first_pc", first_pc, 32'h600);

        // Timestamp wrap: capture across 0xFFFF -> 0x0000.
        for (int i = 0; i < 70000 && tb_ts != 16'hFFFA; i++) tick();
        pulse_arm();
        for (int k = 0; k < 9; k++) retire(32'h700 + 32'(4 * k), k == 0);
        drain(1'b0);
        check("wrap_ts_max", popped_ts[4], 16'hFFFF);
        check("wrap_ts_zero", popped_ts[5], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
